// File: rtl/key_event_pkg.sv
// Shared types and elaboration helpers for the key event front end.
package key_event_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DEB_P   = 3'd1,
        PRESSED = 3'd2,
        HELD    = 3'd3,
        DEB_R   = 3'd4
    } key_state_t;

    // One counter serves debounce, long-press and repeat timing, so size it for the largest.
    function automatic int cnt_width(input int deb, input int lng, input int rep);
        int m;
        m = deb;
        if (lng > m) m = lng;
        if (rep > m) m = rep;
        return $clog2(m + 1);
    endfunction

    function automatic bit params_ok(input int deb, input int lng, input int rep);
        return (deb >= 1) && (lng >= 1) && (rep >= 1);
    endfunction

endpackage

// File: rtl/key_event_ctrl_if.sv
// Key inputs and event strobes between the button front end and its consumers.
interface key_event_ctrl_if #(
    parameter int N_KEYS = 4
) ();
    logic [N_KEYS-1:0] keys_raw;
    logic [N_KEYS-1:0] repeat_en;
    logic [N_KEYS-1:0] key_level;
    logic [N_KEYS-1:0] press_pulse;
    logic [N_KEYS-1:0] release_pulse;
    logic [N_KEYS-1:0] long_pulse;
    logic [N_KEYS-1:0] repeat_pulse;

    modport master (
        output keys_raw, repeat_en,
        input  key_level, press_pulse, release_pulse, long_pulse, repeat_pulse
    );

    modport slave (
        input  keys_raw, repeat_en,
        output key_level, press_pulse, release_pulse, long_pulse, repeat_pulse
    );
endinterface

// File: rtl/key_event_chan.sv
// One key channel: 2-flop synchroniser, polarity normalisation, debounce and
// press/release/long/repeat event FSM with registered outputs.
module key_event_chan
    import key_event_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int LONG_CYCLES     = 50000000,
    parameter int REPEAT_CYCLES   = 10000000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic rstn,
    input  logic key_raw_i,
    input  logic repeat_en_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic long_o,
    output logic repeat_o
);
    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, LONG_CYCLES, REPEAT_CYCLES);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

    logic             sync1_q, sync2_q, s;
    key_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             held_q, held_d;
    logic             level_q, level_d, press_q, press_d, release_q, release_d;
    logic             long_q, long_d, repeat_q, repeat_d;

    assign s = sync2_q ^ ACTIVE_LOW;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        held_d    = held_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (s) begin
                    state_d = DEB_P;
                    cnt_d   = '0;
                end
            end
            DEB_P: begin
                if (!s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PRESSED: begin
                if (!s) begin
                    state_d = DEB_R;
                    cnt_d   = '0;
                end else if (cnt_q == LONG_LAST) begin
                    state_d = HELD;
                    held_d  = 1'b1;
                    cnt_d   = '0;
                    long_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HELD: begin
                // Release wins over a due repeat so no partial-interval strobe escapes.
                if (!s) begin
                    state_d = DEB_R;
                    cnt_d   = '0;
                end else if (!repeat_en_i) begin
                    cnt_d = '0;
                end else if (cnt_q == REP_LAST) begin
                    cnt_d    = '0;
                    repeat_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DEB_R: begin
                if (s) begin
                    state_d = held_q ? HELD : PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d   = IDLE;
                    held_d    = 1'b0;
                    cnt_d     = '0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                held_d  = 1'b0;
            end
        endcase
        level_d = (state_d == PRESSED) || (state_d == HELD) || (state_d == DEB_R);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            sync1_q   <= ACTIVE_LOW;
            sync2_q   <= ACTIVE_LOW;
            state_q   <= IDLE;
            cnt_q     <= '0;
            held_q    <= 1'b0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
        end else begin
            sync1_q   <= key_raw_i;
            sync2_q   <= sync1_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            held_q    <= held_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign long_o    = long_q;
    assign repeat_o  = repeat_q;

endmodule

// File: rtl/key_event_ctrl.sv
// N-channel push-button front end: one independent key_event_chan per key.
module key_event_ctrl
    import key_event_pkg::*;
#(
    parameter int N_KEYS          = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int LONG_CYCLES     = 50000000,
    parameter int REPEAT_CYCLES   = 10000000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input logic             clk,
    input logic             rstn,
    key_event_ctrl_if.slave bus
);
    if (!params_ok(DEBOUNCE_CYCLES, LONG_CYCLES, REPEAT_CYCLES)) begin : g_bad_params
        $error("key_event_ctrl: DEBOUNCE_CYCLES, LONG_CYCLES and REPEAT_CYCLES must be >= 1");
    end

    logic [N_KEYS-1:0] level_w, press_w, release_w, long_w, repeat_w;

    for (genvar g = 0; g < N_KEYS; g++) begin : g_chan
        key_event_chan #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .LONG_CYCLES    (LONG_CYCLES),
            .REPEAT_CYCLES  (REPEAT_CYCLES),
            .ACTIVE_LOW     (ACTIVE_LOW)
        ) u_chan (
            .clk        (clk),
            .rstn       (rstn),
            .key_raw_i  (bus.keys_raw[g]),
            .repeat_en_i(bus.repeat_en[g]),
            .level_o    (level_w[g]),
            .press_o    (press_w[g]),
            .release_o  (release_w[g]),
            .long_o     (long_w[g]),
            .repeat_o   (repeat_w[g])
        );
    end

    assign bus.key_level     = level_w;
    assign bus.press_pulse   = press_w;
    assign bus.release_pulse = release_w;
    assign bus.long_pulse    = long_w;
    assign bus.repeat_pulse  = repeat_w;

endmodule

// File: tb/tb_key_event_ctrl.sv
// Bench for key_event_ctrl: directed scenarios plus random key activity, all
// compared cycle by cycle against a run-length/timestamp model of the key rules.
module tb_key_event_ctrl;
    localparam int D = 4;
    localparam int L = 20;
    localparam int R = 8;

    logic clk = 1'b0;
    logic rstn;
    int   checks = 0;
    int   errors = 0;

    key_event_ctrl_if #(.N_KEYS(4)) bus ();

    key_event_ctrl #(
        .N_KEYS(4), .DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .REPEAT_CYCLES(R), .ACTIVE_LOW(1'b1)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: a level flips after D+1 identical synchronised samples;
    // long/repeat fire a fixed number of edges after the latest restart point.
    int   cyc = 0;
    bit   m_s1[4], m_s2[4], m_lvl[4], m_held[4], m_cur[4];
    int   m_run[4], m_press_e[4], m_zero_e[4], m_long_e[4], m_rep_e[4], m_en0_e[4];
    logic [3:0] exp_level, exp_press, exp_rel, exp_long, exp_rep;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    always @(posedge clk) begin
        cyc++;
        for (int k = 0; k < 4; k++) begin
            bit s;
            int anchor;
            exp_press[k] = 1'b0;
            exp_rel[k]   = 1'b0;
            exp_long[k]  = 1'b0;
            exp_rep[k]   = 1'b0;
            if (!rstn) begin
                m_s1[k] = 1'b0; m_s2[k] = 1'b0; m_lvl[k] = 1'b0; m_held[k] = 1'b0;
                m_cur[k] = 1'b0; m_run[k] = 1;
            end else begin
                s = m_s2[k];
                if (s == m_cur[k]) m_run[k]++;
                else begin m_cur[k] = s; m_run[k] = 1; end
                if (!s) m_zero_e[k] = cyc;
                if (!bus.repeat_en[k]) m_en0_e[k] = cyc;
                if (s != m_lvl[k]) begin
                    if (m_run[k] == D + 1) begin
                        m_lvl[k] = s;
                        if (s) begin exp_press[k] = 1'b1; m_press_e[k] = cyc; end
                        else begin exp_rel[k] = 1'b1; m_held[k] = 1'b0; end
                    end
                end else if (s) begin
                    if (!m_held[k]) begin
                        anchor = imax(m_press_e[k], m_zero_e[k] + 1);
                        if (cyc - anchor == L) begin
                            exp_long[k] = 1'b1; m_held[k] = 1'b1; m_long_e[k] = cyc;
                        end
                    end else if (bus.repeat_en[k]) begin
                        anchor = imax(imax(m_long_e[k], m_zero_e[k] + 1), imax(m_rep_e[k], m_en0_e[k]));
                        if (cyc - anchor == R) begin exp_rep[k] = 1'b1; m_rep_e[k] = cyc; end
                    end
                end
                m_s2[k] = m_s1[k];
                m_s1[k] = ~bus.keys_raw[k];
            end
            exp_level[k] = m_lvl[k];
        end
    end

    function automatic logic [19:0] outs();
        return {bus.key_level, bus.press_pulse, bus.release_pulse, bus.long_pulse, bus.repeat_pulse};
    endfunction

    function automatic logic [19:0] expv();
        return {exp_level, exp_press, exp_rel, exp_long, exp_rep};
    endfunction

    task automatic test_reset();
        rstn = 1'b0;
        bus.keys_raw  = 4'hF;
        bus.repeat_en = 4'h0;
        repeat (3) @(negedge clk);
        checks++;
        if (outs() !== 20'h0) begin
            errors++; $display("FAIL reset_outputs got=%h exp=%h", outs(), 20'h0);
        end
        rstn = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (outs() !== expv()) begin
                errors++; $display("FAIL reset_idle c=%0d got=%h exp=%h", c, outs(), expv());
            end
        end
    endtask

    task automatic test_clean_press();
        int press_at = -1, rel_at = -1, n_long = 0;
        bus.repeat_en = 4'h0;
        for (int c = 0; c < 30; c++) begin
            bus.keys_raw[0] = (c < 15) ? 1'b0 : 1'b1;
            @(negedge clk);
            checks++;
            if (outs() !== expv()) begin
                errors++; $display("FAIL clean_press_model c=%0d got=%h exp=%h", c, outs(), expv());
            end
            if (bus.press_pulse[0] === 1'b1 && press_at < 0) press_at = c;
            if (bus.release_pulse[0] === 1'b1 && rel_at < 0) rel_at = c;
            if (bus.long_pulse[0] === 1'b1) n_long++;
            if (c == 10) begin
                checks++;
                if (bus.key_level[0] !== 1'b1) begin
                    errors++; $display("FAIL clean_press_level got=%b exp=1", bus.key_level[0]);
                end
            end
        end
        checks++;
        if (press_at !== 6) begin errors++; $display("FAIL clean_press_latency got=%0d exp=6", press_at); end
        checks++;
        if (rel_at !== 21) begin errors++; $display("FAIL clean_release_latency got=%0d exp=21", rel_at); end
        checks++;
        if (n_long !== 0) begin errors++; $display("FAIL clean_press_no_long got=%0d exp=0", n_long); end
    endtask

    task automatic test_bounce();
        int press_at = -1, n_press = 0, n_early = 0;
        bus.repeat_en = 4'h0;
        for (int c = 0; c < 40; c++) begin
            if (c < 12) bus.keys_raw[1] = ((c / 2) % 2 == 0) ? 1'b0 : 1'b1;
            else        bus.keys_raw[1] = (c < 25) ? 1'b0 : 1'b1;
            @(negedge clk);
            checks++;
            if (outs() !== expv()) begin
                errors++; $display("FAIL bounce_model c=%0d got=%h exp=%h", c, outs(), expv());
            end
            if (bus.press_pulse[1] === 1'b1) begin n_press++; if (press_at < 0) press_at = c; end
            if (c < 18 && (bus.press_pulse[1] | bus.release_pulse[1] | bus.long_pulse[1]) !== 1'b0) n_early++;
        end
        checks++;
        if (n_press !== 1) begin errors++; $display("FAIL bounce_press_count got=%0d exp=1", n_press); end
        checks++;
        if (press_at !== 18) begin errors++; $display("FAIL bounce_press_time got=%0d exp=18", press_at); end
        checks++;
        if (n_early !== 0) begin errors++; $display("FAIL bounce_glitch_events got=%0d exp=0", n_early); end
    endtask

    task automatic test_long_repeat();
        int press_at = -1, long_at = -1, rep_first = -1, n_rep = 0, n_rel = 0;
        bus.repeat_en = 4'b0100;
        for (int c = 0; c < 75; c++) begin
            bus.keys_raw[2] = (c < 60) ? 1'b0 : 1'b1;
            @(negedge clk);
            checks++;
            if (outs() !== expv()) begin
                errors++; $display("FAIL long_repeat_model c=%0d got=%h exp=%h", c, outs(), expv());
            end
            if (bus.press_pulse[2] === 1'b1 && press_at < 0) press_at = c;
            if (bus.long_pulse[2] === 1'b1 && long_at < 0) long_at = c;
            if (bus.repeat_pulse[2] === 1'b1) begin n_rep++; if (rep_first < 0) rep_first = c; end
            if (bus.release_pulse[2] === 1'b1) n_rel++;
        end
        checks++;
        if (long_at - press_at !== L) begin
            errors++; $display("FAIL long_after_press got=%0d exp=%0d", long_at - press_at, L);
        end
        checks++;
        if (rep_first !== 34) begin errors++; $display("FAIL first_repeat_time got=%0d exp=34", rep_first); end
        checks++;
        if (n_rep !== 4) begin errors++; $display("FAIL repeat_count got=%0d exp=4", n_rep); end
        checks++;
        if (n_rel !== 1) begin errors++; $display("FAIL long_release_count got=%0d exp=1", n_rel); end
    endtask

    task automatic test_release_glitch();
        int n_press = 0, n_long = 0, n_rep = 0, n_rel = 0, n_drop = 0;
        bus.repeat_en = 4'b1000;
        for (int c = 0; c < 65; c++) begin
            bus.keys_raw[3] = (c == 30 || c == 31 || c >= 50) ? 1'b1 : 1'b0;
            @(negedge clk);
            checks++;
            if (outs() !== expv()) begin
                errors++; $display("FAIL glitch_model c=%0d got=%h exp=%h", c, outs(), expv());
            end
            if (bus.press_pulse[3] === 1'b1) n_press++;
            if (bus.long_pulse[3] === 1'b1) n_long++;
            if (bus.repeat_pulse[3] === 1'b1) n_rep++;
            if (bus.release_pulse[3] === 1'b1) n_rel++;
            if (c >= 6 && c <= 55 && bus.key_level[3] !== 1'b1) n_drop++;
        end
        checks++;
        if (n_press !== 1 || n_long !== 1) begin
            errors++; $display("FAIL glitch_refire got=press%0d/long%0d exp=press1/long1", n_press, n_long);
        end
        checks++;
        if (n_rep !== 2) begin errors++; $display("FAIL glitch_repeat_count got=%0d exp=2", n_rep); end
        checks++;
        if (n_rel !== 1) begin errors++; $display("FAIL glitch_release_count got=%0d exp=1", n_rel); end
        checks++;
        if (n_drop !== 0) begin errors++; $display("FAIL glitch_level_drop got=%0d exp=0", n_drop); end
    endtask

    task automatic test_reset_mid_hold();
        int long_at = -1, press2_at = -1;
        bus.repeat_en = 4'h0;
        for (int c = 0; c < 60; c++) begin
            bus.keys_raw[0] = (c < 45) ? 1'b0 : 1'b1;
            rstn = (c == 30) ? 1'b0 : 1'b1;
            @(negedge clk);
            checks++;
            if (outs() !== expv()) begin
                errors++; $display("FAIL reset_hold_model c=%0d got=%h exp=%h", c, outs(), expv());
            end
            if (bus.long_pulse[0] === 1'b1 && long_at < 0) long_at = c;
            if (bus.press_pulse[0] === 1'b1 && c > 30 && press2_at < 0) press2_at = c;
            if (c == 30) begin
                checks++;
                if (outs() !== 20'h0) begin
                    errors++; $display("FAIL reset_hold_clear got=%h exp=%h", outs(), 20'h0);
                end
            end
        end
        checks++;
        if (long_at !== 26) begin errors++; $display("FAIL reset_hold_long got=%0d exp=26", long_at); end
        checks++;
        if (press2_at !== 37) begin errors++; $display("FAIL reset_hold_repress got=%0d exp=37", press2_at); end
    endtask

    task automatic test_simultaneous();
        int n_rep2 = 0, n_rep3 = 0;
        bus.repeat_en = 4'b0100;
        for (int c = 0; c < 55; c++) begin
            bus.keys_raw[2] = (c < 40) ? 1'b0 : 1'b1;
            bus.keys_raw[3] = (c < 40) ? 1'b0 : 1'b1;
            @(negedge clk);
            checks++;
            if (outs() !== expv()) begin
                errors++; $display("FAIL simul_model c=%0d got=%h exp=%h", c, outs(), expv());
            end
            if (bus.repeat_pulse[2] === 1'b1) n_rep2++;
            if (bus.repeat_pulse[3] === 1'b1) n_rep3++;
            if (c == 6) begin
                checks++;
                if (bus.press_pulse !== 4'b1100) begin
                    errors++; $display("FAIL simul_press got=%b exp=1100", bus.press_pulse);
                end
            end
            if (c == 26) begin
                checks++;
                if (bus.long_pulse !== 4'b1100) begin
                    errors++; $display("FAIL simul_long got=%b exp=1100", bus.long_pulse);
                end
            end
        end
        checks++;
        if (n_rep2 !== 1 || n_rep3 !== 0) begin
            errors++; $display("FAIL simul_repeat got=ch2:%0d/ch3:%0d exp=ch2:1/ch3:0", n_rep2, n_rep3);
        end
    endtask

    task automatic test_random();
        int left[4] = '{0, 0, 0, 0};
        for (int c = 0; c < 2000; c++) begin
            for (int k = 0; k < 4; k++) begin
                if (left[k] == 0) begin
                    bus.keys_raw[k] = 1'($urandom_range(0, 1));
                    left[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 70))
                                                          : int'($urandom_range(1, 7));
                end else begin
                    left[k]--;
                end
                if ($urandom_range(0, 39) == 0) bus.repeat_en[k] = ~bus.repeat_en[k];
            end
            rstn = (c < 1950 && $urandom_range(0, 599) == 0) ? 1'b0 : 1'b1;
            if (c >= 1950) bus.keys_raw = 4'hF;
            @(negedge clk);
            checks++;
            if (outs() !== expv()) begin
                errors++; $display("FAIL random_model c=%0d got=%h exp=%h", c, outs(), expv());
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_long_repeat();
        test_release_glitch();
        test_reset_mid_hold();
        test_simultaneous();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_event_ctrl.md
Name: key_event_ctrl

Overview:
- Parametrised N-channel push-button front end for the bus demo top. It replaces ad-hoc per-key edge logic.
- Per channel: synchronises a raw key, debounces it, and emits single-cycle press, release, long-press and auto-repeat events.
- Downstream master/slave control logic consumes these events as clean strobes (address load, request issue, mode toggle).

Parameters:
- N_KEYS, 4, number of independent key channels.
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a level change (>=1).
- LONG_CYCLES, 50000000, debounced-press cycles before long_pulse (>=1).
- REPEAT_CYCLES, 10000000, interval between repeat_pulse while held (>=1).
- ACTIVE_LOW, 1, 1 = raw key reads 0 when pressed.

Ports:
- clk  input  1  system clock.
- rstn  input  1  reset, synchronous, active-low.
- keys_raw  input  N_KEYS  asynchronous raw key inputs.
- repeat_en  input  N_KEYS  per-channel auto-repeat enable.
- key_level  output  N_KEYS  debounced level, 1 = pressed.
- press_pulse  output  N_KEYS  1-cycle strobe on accepted press.
- release_pulse  output  N_KEYS  1-cycle strobe on accepted release.
- long_pulse  output  N_KEYS  1-cycle strobe when press reaches LONG_CYCLES.
- repeat_pulse  output  N_KEYS  1-cycle strobe every REPEAT_CYCLES after long press.

Behaviour:
- Clock and reset:
  - Single clock clk.
  - Reset is synchronous, active-low on rstn.
  - Sampled at the clk edge, rstn=0: all outputs 0 from the following cycle, all FSMs IDLE, counters 0, held flags 0.
  - Sync flops are loaded with the not-pressed value.
- Input conditioning:
  - Each keys_raw bit passes through a 2-flop synchroniser, then is normalised so s=1 means pressed (inverted when ACTIVE_LOW=1).
- Per-channel FSM:
  - Channels are fully independent; each has a counter of width $clog2(max(DEBOUNCE,LONG,REPEAT)+1) and a held flag.
  - IDLE: s=1 -> DEB_P, cnt=0.
  - DEB_P: s=0 -> IDLE (bounce rejected, no event). Otherwise count; at DEBOUNCE_CYCLES stable cycles -> PRESSED, cnt=0.
  - PRESSED: s=0 -> DEB_R, cnt=0. Otherwise count; at LONG_CYCLES -> HELD, held=1, cnt=0.
  - HELD: s=0 -> DEB_R, cnt=0.
    - repeat_en=1: count; at REPEAT_CYCLES issue repeat, cnt=0.
    - repeat_en=0: cnt held at 0.
  - DEB_R: s=1 -> PRESSED if held=0, HELD if held=1, cnt=0, no event. Otherwise count; at DEBOUNCE_CYCLES -> IDLE, held=0.
- Outputs:
  - All outputs are registered.
  - key_level is 1 in PRESSED, HELD and DEB_R; 0 otherwise.
  - Each pulse is high exactly the first cycle after the causing transition and never for two consecutive cycles.
- Latency:
  - Raw key first sampled pressed at edge 0 and stable -> press_pulse and key_level rise after edge 2+DEBOUNCE_CYCLES.
  - Release is symmetric: release_pulse after edge 2+DEBOUNCE_CYCLES from the first sampled release.
  - long_pulse follows press_pulse by exactly LONG_CYCLES cycles.
  - The first repeat_pulse follows long_pulse by REPEAT_CYCLES cycles, and every REPEAT_CYCLES thereafter.
- Boundary conditions:
  - Glitches shorter than DEBOUNCE_CYCLES in either direction produce no events.
  - A glitch during DEB_R does not re-fire press or long.
  - Release during a repeat interval: no partial repeat pulse.
  - A key held through reset produces press_pulse 2+DEBOUNCE_CYCLES cycles after rstn returns high.
  - repeat_en toggling mid-interval restarts the interval from 0 when re-enabled.
  - Simultaneous events on different channels appear in the same cycle.

Decomposition:
- Package key_event_pkg holds:
  - key_state_t enum (IDLE, DEB_P, PRESSED, HELD, DEB_R);
  - a cnt_width function;
  - elaboration assertions on parameter minimums.
- Sub-module key_event_chan implements one channel (sync, normalise, FSM, counter).
- The top instantiates N_KEYS copies in a generate loop.

Test Plan:
- Bench parameters: N_KEYS=4, DEBOUNCE_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=8, ACTIVE_LOW=1.
- Clean press: keys_raw[0]=0 first sampled at edge 10, held 15 cycles, then released -> press_pulse[0] after edge 16; key_level[0]=1; release_pulse[0] 6 cycles after first sampled release; no long_pulse.
- Bounce: keys_raw[1] toggles every 2 cycles for 12 cycles, then stays 0 -> exactly one press_pulse[1], 6 cycles after the final stable edge; zero events during toggling.
- Long plus repeat: repeat_en[2]=1, keys_raw[2] held 60 cycles -> long_pulse 20 after press_pulse, then repeat_pulse every 8 cycles until release; one release_pulse.
- Release glitch: in HELD, keys_raw[3]=1 for 2 cycles -> key_level stays 1; no release, press or long; repeats continue.
- Reset mid-hold: rstn=0 for 1 cycle while key0 is HELD -> all outputs 0 next cycle; key still held -> new press_pulse 6 cycles after reset release.
- Simultaneous keys: keys 2 and 3 pressed the same cycle with repeat_en=4'b0100 -> coincident press and long pulses; only channel 2 produces repeat_pulse.
